dm_resp: RTL and testbench

Multi-cycle data-memory responder: the memory-side end of the load/store interface driven by the multi-cycle controller's `DMRd`/`DMWr` strobes. It captures a word access, inserts a parameterised number of wait states, commits the write or returns read data, and holds the controller via `stall` until the access completes. It sits between the controller/ALU result path and the register-file write-back mux (`WD_Src = 1` source).

---
 rtl/dm_resp_if.sv | 21 ++
 rtl/dm_resp.sv | 143 ++++++++++++++
 tb/tb_dm_resp.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dm_resp_if.sv
// Load/store handshake between the multi-cycle controller and the data-memory responder.
interface dm_resp_if;
    logic        DMRd;
    logic        DMWr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;

    modport master (
        output DMRd, DMWr, addr, wdata,
        input  rdata, stall, done, err
    );

    modport slave (
        input  DMRd, DMWr, addr, wdata,
        output rdata, stall, done, err
    );
endinterface

// File: rtl/dm_resp.sv
// Multi-cycle data-memory responder: captures one word access, waits LATENCY
// edges, then commits the store or returns the load data in a DONE cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for DMRd/DMWr; a request here is captured on the edge
// BUSY  | wait states; cnt counts down, DONE entered on the 1->0 edge
// DONE  | done (and err on a bad access) high, stall low, then back to IDLE
module dm_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic     clk,
    input  logic     rst,
    dm_resp_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_BAD} op_t;

    state_t             state, state_d;
    logic [3:0]         cnt, cnt_d;

    op_t                op_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [31:0]        wdata_q;
    logic               aerr_q;

    logic               req;
    op_t                in_op;
    logic [ADDR_W-1:0]  in_idx;
    logic               in_aerr;

    op_t                cur_op;
    logic [ADDR_W-1:0]  cur_idx;
    logic [31:0]        cur_wdata;
    logic               cur_aerr;
    logic               cur_err;
    logic               enter_done;
    logic               mem_we;

    logic [31:0]        done_rdata;
    logic               done_q;
    logic               err_q;

    logic [31:0]        mem [2**ADDR_W];

    // Next state, wait counter, and the access attributes seen by the commit
    // edge: live inputs when committing straight out of IDLE (LATENCY=1),
    // captured copies otherwise.
    always_comb begin
        req     = bus.DMRd | bus.DMWr;
        in_op   = (bus.DMRd & bus.DMWr) ? OP_BAD : (bus.DMWr ? OP_WR : OP_RD);
        in_idx  = bus.addr[ADDR_W+1:2];
        in_aerr = (|bus.addr[1:0]) | (|bus.addr[31:ADDR_W+2]);

        state_d    = state;
        cnt_d      = cnt;
        enter_done = 1'b0;
        cur_op     = op_q;
        cur_idx    = idx_q;
        cur_wdata  = wdata_q;
        cur_aerr   = aerr_q;

        case (state)
            IDLE: begin
                cur_op    = in_op;
                cur_idx   = in_idx;
                cur_wdata = bus.wdata;
                cur_aerr  = in_aerr;
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_d    = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cur_err = (cur_op == OP_BAD) | cur_aerr;
        // rst gates the write so an access cannot commit while reset is held.
        mem_we  = enter_done & (cur_op == OP_WR) & ~cur_err & rst;
    end

    // State, counter, captured access, and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            op_q       <= OP_RD;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            aerr_q     <= 1'b0;
            done_rdata <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            done_q <= enter_done;
            err_q  <= enter_done & cur_err;
            if (state == IDLE && req) begin
                op_q    <= in_op;
                idx_q   <= in_idx;
                wdata_q <= bus.wdata;
                aerr_q  <= in_aerr;
            end
            if (enter_done) begin
                if (cur_err)
                    done_rdata <= 32'd0;
                else if (cur_op == OP_RD)
                    done_rdata <= mem[cur_idx];
            end
        end
    end

    // Storage array; deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[cur_idx] <= cur_wdata;
    end

    // DONE is the only cycle that releases the controller while busy.
    always_comb begin
        bus.stall = ((state == IDLE) & req) | (state == BUSY);
        bus.done  = done_q;
        bus.err   = err_q;
        bus.rdata = done_rdata;
    end

endmodule

// File: tb/tb_dm_resp.sv
// Directed bench for dm_resp: four instances at LATENCY 1, 2, 4 and 15.
module tb_dm_resp;

    logic clk;
    logic rst;
    logic rst4;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        stall;
        logic        done;
        logic        err;
        logic [31:0] rdata;
    } obs_t;

    dm_resp_if i1 ();
    dm_resp_if i2 ();
    dm_resp_if i4 ();
    dm_resp_if i15 ();

    dm_resp #(.ADDR_W(10), .LATENCY(1))  u1  (.clk(clk), .rst(rst),  .bus(i1));
    dm_resp #(.ADDR_W(10), .LATENCY(2))  u2  (.clk(clk), .rst(rst),  .bus(i2));
    dm_resp #(.ADDR_W(10), .LATENCY(4))  u4  (.clk(clk), .rst(rst4), .bus(i4));
    dm_resp #(.ADDR_W(10), .LATENCY(15)) u15 (.clk(clk), .rst(rst),  .bus(i15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        case (w)
            1:  begin i1.DMRd  = rd; i1.DMWr  = wr; i1.addr  = a; i1.wdata  = wd; end
            2:  begin i2.DMRd  = rd; i2.DMWr  = wr; i2.addr  = a; i2.wdata  = wd; end
            4:  begin i4.DMRd  = rd; i4.DMWr  = wr; i4.addr  = a; i4.wdata  = wd; end
            default: begin i15.DMRd = rd; i15.DMWr = wr; i15.addr = a; i15.wdata = wd; end
        endcase
    endtask

    function automatic obs_t get(input int w);
        obs_t o;
        case (w)
            1:  o = '{i1.stall,  i1.done,  i1.err,  i1.rdata};
            2:  o = '{i2.stall,  i2.done,  i2.err,  i2.rdata};
            4:  o = '{i4.stall,  i4.done,  i4.err,  i4.rdata};
            default: o = '{i15.stall, i15.done, i15.err, i15.rdata};
        endcase
        return o;
    endfunction

    // One access: counts stall cycles until done, scrambles addr/wdata after
    // the capture edge, then checks the DONE cycle and the cycle after it.
    task automatic access(input int w, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int lat, input logic exp_err,
                          input logic chk_rd, input logic [31:0] exp_rd,
                          input string tag);
        int   n;
        logic seen;
        obs_t o;
        n    = 0;
        seen = 1'b0;
        @(negedge clk);
        drive(w, rd, wr, a, wd);
        for (int k = 0; k < 40; k++) begin
            #1;
            o = get(w);
            if (o.done) begin
                seen = 1'b1;
                break;
            end
            if (o.stall) n++;
            @(negedge clk);
            if (k == 0) drive(w, rd, wr, 32'hFFFF_FFFF, 32'h0BAD_0BAD);
        end
        chk({tag, " done seen"}, 32'(seen), 32'd1);
        chk({tag, " stall cycles"}, 32'(n), 32'(lat));
        chk({tag, " err"}, 32'(o.err), 32'(exp_err));
        chk({tag, " stall in done"}, 32'(o.stall), 32'd0);
        if (chk_rd) chk({tag, " rdata"}, o.rdata, exp_rd);
        @(negedge clk);
        drive(w, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        o = get(w);
        chk({tag, " done drops"}, 32'(o.done), 32'd0);
        chk({tag, " err drops"}, 32'(o.err), 32'd0);
    endtask

    initial begin
        obs_t o;
        rst  = 1'b0;
        rst4 = 1'b0;
        drive(1, 0, 0, 0, 0);
        drive(2, 0, 0, 0, 0);
        drive(4, 0, 0, 0, 0);
        drive(15, 0, 0, 0, 0);
        #2;
        o = get(2);
        chk("reset done", 32'(o.done), 32'd0);
        chk("reset err", 32'(o.err), 32'd0);
        chk("reset rdata", o.rdata, 32'd0);
        chk("reset stall idle", 32'(o.stall), 32'd0);
        drive(2, 1, 0, 32'h10, 0);
        #1;
        o = get(2);
        chk("reset stall follows req", 32'(o.stall), 32'd1);
        drive(2, 0, 0, 0, 0);
        @(negedge clk);
        rst  = 1'b1;
        rst4 = 1'b1;

        // LATENCY=2 store then load, error cases
        access(2, 0, 1, 32'h10, 32'hDEAD_BEEF, 2, 0, 0, 0, "l2 sw 0x10");
        access(2, 1, 0, 32'h10, 32'h0, 2, 0, 1, 32'hDEAD_BEEF, "l2 lw 0x10");
        access(2, 0, 1, 32'h12, 32'h5, 2, 1, 1, 32'h0, "l2 sw misaligned");
        access(2, 1, 0, 32'h10, 32'h0, 2, 0, 1, 32'hDEAD_BEEF, "l2 mem4 kept");
        access(2, 1, 0, 32'h1000, 32'h0, 2, 1, 1, 32'h0, "l2 lw out of range");
        access(2, 1, 1, 32'h10, 32'h1111, 2, 1, 1, 32'h0, "l2 both strobes");
        access(2, 1, 0, 32'h10, 32'h0, 2, 0, 1, 32'hDEAD_BEEF, "l2 no bad write");

        // LATENCY=1 preload then back-to-back loads with DMRd held
        access(1, 0, 1, 32'h0, 32'h1, 1, 0, 0, 0, "l1 sw 0x0");
        access(1, 0, 1, 32'h4, 32'h2, 1, 0, 0, 0, "l1 sw 0x4");
        @(negedge clk);
        drive(1, 1, 0, 32'h0, 0);
        #1;
        o = get(1);
        chk("b2b c0 stall", 32'(o.stall), 32'd1);
        chk("b2b c0 done", 32'(o.done), 32'd0);
        @(negedge clk);
        #1;
        o = get(1);
        chk("b2b c1 done", 32'(o.done), 32'd1);
        chk("b2b c1 rdata", o.rdata, 32'h1);
        drive(1, 1, 0, 32'h4, 0);
        @(negedge clk);
        #1;
        o = get(1);
        chk("b2b c2 done", 32'(o.done), 32'd0);
        chk("b2b c2 stall", 32'(o.stall), 32'd1);
        @(negedge clk);
        #1;
        o = get(1);
        chk("b2b c3 done", 32'(o.done), 32'd1);
        chk("b2b c3 rdata", o.rdata, 32'h2);
        drive(1, 0, 0, 0, 0);

        // LATENCY=15 sweep point
        access(15, 0, 1, 32'h3FC, 32'hCAFE_F00D, 15, 0, 0, 0, "l15 sw");
        access(15, 1, 0, 32'h3FC, 32'h0, 15, 0, 1, 32'hCAFE_F00D, "l15 lw");

        // LATENCY=4 reset during the second BUSY cycle
        access(4, 0, 1, 32'h20, 32'h1234_5678, 4, 0, 0, 0, "l4 sw prior");
        access(4, 1, 0, 32'h20, 32'h0, 4, 0, 1, 32'h1234_5678, "l4 lw prior");
        @(negedge clk);
        drive(4, 0, 1, 32'h20, 32'hAA);
        @(negedge clk);
        @(negedge clk);
        #1;
        o = get(4);
        chk("l4 stall in busy2", 32'(o.stall), 32'd1);
        rst4 = 1'b0;
        drive(4, 0, 0, 0, 0);
        #1;
        o = get(4);
        chk("l4 rst rdata", o.rdata, 32'd0);
        chk("l4 rst done", 32'(o.done), 32'd0);
        chk("l4 rst err", 32'(o.err), 32'd0);
        chk("l4 rst stall", 32'(o.stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        access(4, 1, 0, 32'h20, 32'h0, 4, 0, 1, 32'h1234_5678, "l4 after rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
